// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Brief    : Stall/flush controller for the 5-stage MIPS pipeline. Merges the
//            fetch, decode, multiplier and memory stall requests into one
//            per-stage hold vector, sequences the multi-cycle MUL in EX, and
//            turns decode redirects into IF/ID flushes. A redirect that
//            arrives while IF/ID is held is deferred until IF/ID can move.
//            Optional macro PIPE_CTRL_PERF_EN enables the stall/flush
//            performance counters; without it both counters read 0.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    // Total EX occupancy of one MUL in cycles (legal 2..15).
    parameter int MUL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active-low
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_mem,
    input  logic        ex_mul_start,
    input  logic        branch_flag,
    output logic [5:0]  stall,
    output logic        flush_ifid,
    output logic        ex_mul_done,
    output logic        mul_busy,
    output logic [15:0] perf_stall_cnt,
    output logic [15:0] perf_flush_cnt
);

    // The BUSY phase lasts MUL_CYCLES-1 cycles; the start cycle (IDLE with
    // ex_mul_start) is the first stalled cycle, so the counter runs to 0
    // from MUL_CYCLES-2.
    localparam logic [3:0] c_CNT_LOAD = 4'(MUL_CYCLES - 2);

    localparam logic [5:0] c_HOLD_MEM  = 6'b011111;
    localparam logic [5:0] c_HOLD_EX   = 6'b001111;
    localparam logic [5:0] c_HOLD_ID   = 6'b000111;
    localparam logic [5:0] c_HOLD_IF   = 6'b000011;
    localparam logic [5:0] c_HOLD_NONE = 6'b000000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_mul_done;
    logic        r_mul_busy;
    logic        r_flush_pend;

    logic        w_ex_stall;
    logic [5:0]  w_stall_raw;
    logic [5:0]  w_stall;
    logic        w_flush;

    // Multiplier occupancy FSM with registered Moore outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_mul_done <= 1'b0;
            r_mul_busy <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ex_mul_start) begin
                        r_state    <= S_BUSY;
                        r_cnt      <= c_CNT_LOAD;
                        r_mul_busy <= 1'b1;
                        r_mul_done <= 1'b0;
                    end
                end
                S_BUSY: begin
                    // A concurrent mem stall does not freeze the multiplier.
                    if (r_cnt == 4'd0) begin
                        r_state    <= S_DONE;
                        r_mul_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    // Hold the result valid until MEM lets EX/MEM advance.
                    if (!stallreq_mem) begin
                        r_state    <= S_IDLE;
                        r_mul_done <= 1'b0;
                        r_mul_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_cnt      <= 4'd0;
                    r_mul_done <= 1'b0;
                    r_mul_busy <= 1'b0;
                end
            endcase
        end
    end

    assign w_ex_stall = ((r_state == S_IDLE) && ex_mul_start) || (r_state == S_BUSY);

    // Single-level priority select of the hold vector, deepest requester wins.
    always_comb begin
        w_stall_raw = c_HOLD_NONE;
        if (stallreq_mem) begin
            w_stall_raw = c_HOLD_MEM;
        end else if (w_ex_stall) begin
            w_stall_raw = c_HOLD_EX;
        end else if (stallreq_id) begin
            w_stall_raw = c_HOLD_ID;
        end else if (stallreq_if) begin
            w_stall_raw = c_HOLD_IF;
        end
    end

    // Outputs are forced quiet while reset is asserted, even though the
    // request inputs may still be toggling.
    assign w_stall = rst ? w_stall_raw : c_HOLD_NONE;
    assign w_flush = rst & (branch_flag | r_flush_pend) & ~w_stall[1];

    // Remember a redirect that could not squash IF/ID because it was held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flush_pend <= 1'b0;
        end else if (w_flush) begin
            r_flush_pend <= 1'b0;
        end else if (branch_flag && w_stall[1]) begin
            r_flush_pend <= 1'b1;
        end
    end

    assign stall       = w_stall;
    assign flush_ifid  = w_flush;
    assign ex_mul_done = r_mul_done;
    assign mul_busy    = r_mul_busy;

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] r_perf_stall;
    logic [15:0] r_perf_flush;

    // Free-running event counters; natural 16-bit wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall <= 16'h0000;
            r_perf_flush <= 16'h0000;
        end else begin
            if (w_stall[0]) begin
                r_perf_stall <= r_perf_stall + 16'h0001;
            end
            if (w_flush) begin
                r_perf_flush <= r_perf_flush + 16'h0001;
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
`else
    assign perf_stall_cnt = 16'h0000;
    assign perf_flush_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire
